// File: rtl/io_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : io_bus_pkg
//  Description : Shared types and constants for the output-port write path.
//  Revision    : 1.0 - initial release
// ============================================================================
package io_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        GAP   = 2'd2
    } io_state_e;

    localparam logic [31:0] OUT_PORT0_ADDR = 32'h0000_0080;
    localparam logic [31:0] OUT_PORT1_ADDR = 32'h0000_0084;

    localparam logic M_CPU = 1'b0;
    localparam logic M_AUX = 1'b1;

endpackage
`default_nettype wire

// File: rtl/io_write_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : io_write_arbiter_if
//  Description : Two-master write request bus plus the output-port write path.
//  Revision    : 1.0 - initial release
// ============================================================================
interface io_write_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] data0;
    logic              ack0;
    logic              req1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] data1;
    logic              ack1;
    logic [ADDR_W-1:0] io_addr;
    logic [DATA_W-1:0] io_datain;
    logic              write_io_enable;
    logic              busy;

    modport master (
        output req0, addr0, data0, req1, addr1, data1,
        input  ack0, ack1, io_addr, io_datain, write_io_enable, busy
    );

    modport slave (
        input  req0, addr0, data0, req1, addr1, data1,
        output ack0, ack1, io_addr, io_datain, write_io_enable, busy
    );
endinterface
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter2
//  Description : Combinational two-way round-robin pick; last grant held by caller.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2
    import io_bus_pkg::*;
(
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_grant_i,
    output logic gnt_idx_o,
    output logic gnt_valid_o
);

    assign gnt_valid_o = req0_i | req1_i;

    // Under contention the master that did not win last time goes first.
    assign gnt_idx_o = (req0_i && req1_i) ? ((last_grant_i == M_CPU) ? M_AUX : M_CPU)
                                          : (req1_i ? M_AUX : M_CPU);

endmodule
`default_nettype wire

// File: rtl/io_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : io_write_arbiter
//  Description : Round-robin arbiter sharing the output-port write path between
//                two masters, one strobe per grant followed by an idle gap.
//  Revision    : 1.0 - initial release
// ============================================================================
module io_write_arbiter
    import io_bus_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int GAP_CYCLES = 1
) (
    input  logic              io_clk,
    input  logic              reset,
    io_write_arbiter_if.slave bus
);

    localparam int CNT_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

    io_state_e         state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              we_q, we_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic              busy_q, busy_d;

    logic              gnt_idx;
    logic              gnt_valid;

    rr_arbiter2 u_rr (
        .req0_i       (bus.req0),
        .req1_i       (bus.req1),
        .last_grant_i (last_grant_q),
        .gnt_idx_o    (gnt_idx),
        .gnt_valid_o  (gnt_valid)
    );

    always_ff @(posedge io_clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= M_AUX;
            cnt_q        <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            we_q         <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            we_q         <= we_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            busy_q       <= busy_d;
        end
    end

    // Outputs are computed one state ahead so strobe/ack/busy come straight from flops.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        data_d       = data_q;
        we_d         = 1'b0;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    state_d      = WRITE;
                    last_grant_d = gnt_idx;
                    we_d         = 1'b1;
                    if (gnt_idx == M_AUX) begin
                        addr_d = bus.addr1;
                        data_d = bus.data1;
                        ack1_d = 1'b1;
                    end else begin
                        addr_d = bus.addr0;
                        data_d = bus.data0;
                        ack0_d = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (GAP_CYCLES == 0) begin
                    state_d = IDLE;
                end else begin
                    state_d = GAP;
                    cnt_d   = GAP_LOAD;
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    assign bus.io_addr         = addr_q;
    assign bus.io_datain       = data_q;
    assign bus.write_io_enable = we_q;
    assign bus.ack0            = ack0_q;
    assign bus.ack1            = ack1_q;
    assign bus.busy            = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_io_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_io_write_arbiter
//  Description : Directed self-checking bench for io_write_arbiter (gaps 0, 1, 3).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_io_write_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    io_write_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();
    io_write_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
    io_write_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus3 ();

    io_write_arbiter #(.ADDR_W(32), .DATA_W(32), .GAP_CYCLES(1)) dut1 (
        .io_clk(clk), .reset(reset), .bus(bus1)
    );
    io_write_arbiter #(.ADDR_W(32), .DATA_W(32), .GAP_CYCLES(0)) dut0 (
        .io_clk(clk), .reset(reset), .bus(bus0)
    );
    io_write_arbiter #(.ADDR_W(32), .DATA_W(32), .GAP_CYCLES(3)) dut3 (
        .io_clk(clk), .reset(reset), .bus(bus3)
    );

    typedef struct {
        logic        req0;
        logic        req1;
        logic [31:0] addr0;
        logic [31:0] data0;
        logic [31:0] addr1;
        logic [31:0] data1;
        logic        we;
        logic        ack0;
        logic        ack1;
        logic        busy;
        logic [31:0] io_addr;
        logic [31:0] io_datain;
    } vec_t;

    vec_t vecs [30];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setv(input int i, input logic r0, input logic r1,
                        input logic [31:0] a0, input logic [31:0] d0,
                        input logic [31:0] a1, input logic [31:0] d1,
                        input logic we, input logic k0, input logic k1, input logic b,
                        input logic [31:0] ea, input logic [31:0] ed);
        vecs[i].req0 = r0;   vecs[i].req1 = r1;
        vecs[i].addr0 = a0;  vecs[i].data0 = d0;
        vecs[i].addr1 = a1;  vecs[i].data1 = d1;
        vecs[i].we = we;     vecs[i].ack0 = k0;  vecs[i].ack1 = k1;
        vecs[i].busy = b;    vecs[i].io_addr = ea; vecs[i].io_datain = ed;
    endtask

    task automatic chk1(input string tag, input logic we, input logic k0, input logic k1,
                        input logic b, input logic [31:0] ea, input logic [31:0] ed);
        check({tag, " we"},   {31'd0, bus1.write_io_enable}, {31'd0, we});
        check({tag, " ack0"}, {31'd0, bus1.ack0}, {31'd0, k0});
        check({tag, " ack1"}, {31'd0, bus1.ack1}, {31'd0, k1});
        check({tag, " busy"}, {31'd0, bus1.busy}, {31'd0, b});
        check({tag, " addr"}, bus1.io_addr, ea);
        check({tag, " data"}, bus1.io_datain, ed);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus1.req0 = 0; bus1.req1 = 0; bus1.addr0 = 0; bus1.data0 = 0; bus1.addr1 = 0; bus1.data1 = 0;
        bus0.req0 = 0; bus0.req1 = 0; bus0.addr0 = 0; bus0.data0 = 0; bus0.addr1 = 0; bus0.data1 = 0;
        bus3.req0 = 0; bus3.req1 = 0; bus3.addr0 = 0; bus3.data0 = 0; bus3.addr1 = 0; bus3.data1 = 0;

        // Vector table for the GAP_CYCLES=1 instance; each row is one clock.
        setv(0,  1, 0, 32'h80, 32'h1234, 32'h0,  32'h0,    1, 1, 0, 1, 32'h80, 32'h1234);
        setv(1,  0, 0, 32'h80, 32'h1234, 32'h0,  32'h0,    0, 0, 0, 1, 32'h80, 32'h1234);
        setv(2,  0, 0, 32'h80, 32'h1234, 32'h0,  32'h0,    0, 0, 0, 0, 32'h80, 32'h1234);
        setv(3,  0, 1, 32'h80, 32'h1234, 32'h84, 32'h5678, 1, 0, 1, 1, 32'h84, 32'h5678);
        setv(4,  0, 0, 32'h80, 32'h1234, 32'h84, 32'h5678, 0, 0, 0, 1, 32'h84, 32'h5678);
        setv(5,  0, 0, 32'h80, 32'h1234, 32'h84, 32'h5678, 0, 0, 0, 0, 32'h84, 32'h5678);
        setv(6,  1, 1, 32'h90, 32'hAAAA, 32'h94, 32'hBBBB, 1, 1, 0, 1, 32'h90, 32'hAAAA);
        setv(7,  0, 1, 32'h90, 32'hAAAA, 32'h94, 32'hBBBB, 0, 0, 0, 1, 32'h90, 32'hAAAA);
        setv(8,  0, 1, 32'h90, 32'hAAAA, 32'h94, 32'hBBBB, 0, 0, 0, 0, 32'h90, 32'hAAAA);
        setv(9,  0, 1, 32'h90, 32'hAAAA, 32'h94, 32'hBBBB, 1, 0, 1, 1, 32'h94, 32'hBBBB);
        setv(10, 1, 0, 32'hEE, 32'hDEAD, 32'h94, 32'hBBBB, 0, 0, 0, 1, 32'h94, 32'hBBBB);
        setv(11, 0, 0, 32'hEE, 32'hDEAD, 32'h94, 32'hBBBB, 0, 0, 0, 0, 32'h94, 32'hBBBB);
        for (int i = 12; i < 30; i++) begin
            int k;
            int g;
            logic m1;
            k  = i - 12;
            g  = k / 3;
            m1 = (g % 2) == 1;
            setv(i, k < 16, k < 16, 32'hA0, 32'h1000, 32'hA4, 32'h2000,
                 (k % 3) == 0, ((k % 3) == 0) && !m1, ((k % 3) == 0) && m1, (k % 3) != 2,
                 m1 ? 32'hA4 : 32'hA0, m1 ? 32'h2000 : 32'h1000);
        end

        // Reset held with a pending request: everything stays quiet.
        bus1.req0 = 1; bus1.addr0 = 32'h80; bus1.data0 = 32'h1234;
        for (int c = 0; c < 3; c++) begin
            step();
            chk1($sformatf("rst%0d", c), 0, 0, 0, 0, 32'h0, 32'h0);
            check($sformatf("rst%0d g0 busy", c), {31'd0, bus0.busy}, 32'd0);
            check($sformatf("rst%0d g3 we", c), {31'd0, bus3.write_io_enable}, 32'd0);
        end
        reset = 0;
        step();
        chk1("rst_release", 1, 1, 0, 1, 32'h80, 32'h1234);
        bus1.req0 = 0;
        step();
        step();
        chk1("rst_settle", 0, 0, 0, 0, 32'h80, 32'h1234);

        for (int i = 0; i < 30; i++) begin
            bus1.req0  = vecs[i].req0;  bus1.req1  = vecs[i].req1;
            bus1.addr0 = vecs[i].addr0; bus1.data0 = vecs[i].data0;
            bus1.addr1 = vecs[i].addr1; bus1.data1 = vecs[i].data1;
            step();
            chk1($sformatf("v%0d", i), vecs[i].we, vecs[i].ack0, vecs[i].ack1,
                 vecs[i].busy, vecs[i].io_addr, vecs[i].io_datain);
        end
        bus1.req0 = 0; bus1.req1 = 0;

        // Reset landing on the WRITE cycle aborts it; the held request is granted again.
        bus1.req0 = 1; bus1.addr0 = 32'hC0; bus1.data0 = 32'hCAFE;
        step();
        chk1("abort_grant", 1, 1, 0, 1, 32'hC0, 32'hCAFE);
        reset = 1;
        step();
        chk1("abort_rst", 0, 0, 0, 0, 32'h0, 32'h0);
        reset = 0;
        step();
        chk1("abort_regrant", 1, 1, 0, 1, 32'hC0, 32'hCAFE);
        bus1.req0 = 0;
        step();
        step();
        chk1("abort_idle", 0, 0, 0, 0, 32'hC0, 32'hCAFE);

        // Zero-gap instance: held req1 gives back-to-back grants.
        reset = 1;
        step();
        reset = 0;
        bus0.req1 = 1; bus0.addr1 = 32'h84; bus0.data1 = 32'h11;
        step();
        check("g0 e1 we",   {31'd0, bus0.write_io_enable}, 32'd1);
        check("g0 e1 ack1", {31'd0, bus0.ack1}, 32'd1);
        check("g0 e1 ack0", {31'd0, bus0.ack0}, 32'd0);
        check("g0 e1 data", bus0.io_datain, 32'h11);
        bus0.data1 = 32'h22;
        step();
        check("g0 e2 we",   {31'd0, bus0.write_io_enable}, 32'd0);
        check("g0 e2 busy", {31'd0, bus0.busy}, 32'd0);
        step();
        check("g0 e3 we",   {31'd0, bus0.write_io_enable}, 32'd1);
        check("g0 e3 ack1", {31'd0, bus0.ack1}, 32'd1);
        check("g0 e3 data", bus0.io_datain, 32'h22);
        check("g0 e3 addr", bus0.io_addr, 32'h84);
        step();
        check("g0 e4 we",   {31'd0, bus0.write_io_enable}, 32'd0);
        bus0.req1 = 0;
        step();
        check("g0 e5 we",   {31'd0, bus0.write_io_enable}, 32'd0);
        check("g0 e5 busy", {31'd0, bus0.busy}, 32'd0);
        check("g0 e5 data", bus0.io_datain, 32'h22);

        // Three-cycle gap: held req0 is re-granted exactly five edges later.
        bus3.req0 = 1; bus3.addr0 = 32'h88; bus3.data0 = 32'h77;
        step();
        check("g3 n0 we",   {31'd0, bus3.write_io_enable}, 32'd1);
        check("g3 n0 ack0", {31'd0, bus3.ack0}, 32'd1);
        check("g3 n0 addr", bus3.io_addr, 32'h88);
        for (int c = 1; c <= 4; c++) begin
            step();
            check($sformatf("g3 n%0d we", c),   {31'd0, bus3.write_io_enable}, 32'd0);
            check($sformatf("g3 n%0d ack0", c), {31'd0, bus3.ack0}, 32'd0);
            check($sformatf("g3 n%0d busy", c), {31'd0, bus3.busy}, (c < 4) ? 32'd1 : 32'd0);
        end
        step();
        check("g3 n5 we",   {31'd0, bus3.write_io_enable}, 32'd1);
        check("g3 n5 ack0", {31'd0, bus3.ack0}, 32'd1);
        check("g3 n5 data", bus3.io_datain, 32'h77);
        bus3.req0 = 0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
